// File: rtl/multi_ball_engine.sv
// Multi-ball pong physics engine: on each accepted frame tick it walks every ball slot,
// one per clock, applying wall bounce, paddle hit-test, scoring, motion and periodic speed-up.
module multi_ball_engine #(
    parameter int N_BALLS       = 4,
    parameter int X_MAX         = 640,
    parameter int Y_MIN         = 20,
    parameter int Y_MAX         = 480,
    parameter int BOX           = 4,
    parameter int PADDLE_X      = 4,
    parameter int PADDLE_OFFSET = 2,
    parameter int PADDLE_H      = 15,
    parameter int RATE          = 1,
    parameter int MAX_RATE      = 15,
    parameter int ACCEL_FRAMES  = 30,
    localparam int XW = $clog2(X_MAX) + 1,
    localparam int YW = $clog2(Y_MAX) + 1,
    localparam int RW = $clog2(MAX_RATE) + 1,
    localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic               spawn,
    input  logic [IW-1:0]      spawn_idx,
    input  logic               spawn_dir,
    input  logic [YW-1:0]      left_paddle_y,
    input  logic [YW-1:0]      right_paddle_y,
    input  logic [IW-1:0]      rd_idx,
    output logic [XW-1:0]      rd_x,
    output logic [YW-1:0]      rd_y,
    output logic [XW-1:0]      rd_old_x,
    output logic [YW-1:0]      rd_old_y,
    output logic [RW-1:0]      rd_rate,
    output logic [N_BALLS-1:0] active_mask,
    output logic               busy,
    output logic               update_done,
    output logic               lhs_score,
    output logic               rhs_score,
    output logic               bounce,
    output logic [IW-1:0]      event_idx
);

    localparam int AW = ((XW > YW) ? XW : YW) + 1;
    localparam int CW = $clog2(ACCEL_FRAMES) + 1;

    localparam logic [AW-1:0] BOX_A  = AW'(BOX);
    localparam logic [AW-1:0] XMAX_A = AW'(X_MAX);
    localparam logic [AW-1:0] XMIN_A = AW'(PADDLE_X + PADDLE_OFFSET);
    localparam logic [AW-1:0] YMIN_A = AW'(Y_MIN);
    localparam logic [AW-1:0] YMAX_A = AW'(Y_MAX);
    localparam logic [AW-1:0] PH_A   = AW'(PADDLE_H);

    localparam logic [XW-1:0] CX       = XW'(X_MAX / 2);
    localparam logic [YW-1:0] CY       = YW'((Y_MIN + Y_MAX) / 2);
    localparam logic [RW-1:0] RATE_V   = RW'(RATE);
    localparam logic [RW-1:0] MAXR_V   = RW'(MAX_RATE);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_BALLS - 1);
    localparam logic [CW-1:0] ACC_LAST = CW'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      accel_cnt;
    logic               accel_pass;

    logic [XW-1:0]      x_q     [N_BALLS];
    logic [YW-1:0]      y_q     [N_BALLS];
    logic [XW-1:0]      old_x_q [N_BALLS];
    logic [YW-1:0]      old_y_q [N_BALLS];
    logic [RW-1:0]      rate_q  [N_BALLS];
    logic [N_BALLS-1:0] x_dir_q;
    logic [N_BALLS-1:0] y_dir_q;
    logic [N_BALLS-1:0] active_q;

    logic [AW-1:0] cur_x, cur_y, cur_r, lp_a, rp_a;
    logic          left_hit, right_hit;
    logic          y_bounce, x_bounce, lhs_evt, rhs_evt;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          next_x_dir, next_y_dir;
    logic [RW-1:0] next_rate;

    assign rd_x        = x_q[rd_idx];
    assign rd_y        = y_q[rd_idx];
    assign rd_old_x    = old_x_q[rd_idx];
    assign rd_old_y    = old_y_q[rd_idx];
    assign rd_rate     = rate_q[rd_idx];
    assign active_mask = active_q;
    assign busy        = (state != IDLE);

    // Next-state of the slot under the scan pointer; all compares are widened so nothing wraps.
    always_comb begin
        cur_x = AW'(x_q[idx]);
        cur_y = AW'(y_q[idx]);
        cur_r = AW'(rate_q[idx]);
        lp_a  = AW'(left_paddle_y);
        rp_a  = AW'(right_paddle_y);

        left_hit  = (cur_y < lp_a + PH_A) && (cur_y + BOX_A > lp_a);
        right_hit = (cur_y < rp_a + PH_A) && (cur_y + BOX_A > rp_a);

        y_bounce   = 1'b0;
        next_y     = y_q[idx];
        next_y_dir = y_dir_q[idx];
        if (y_dir_q[idx]) begin
            if (cur_y + BOX_A + cur_r > YMAX_A) begin
                y_bounce   = 1'b1;
                next_y_dir = 1'b0;
            end else begin
                next_y = YW'(cur_y + cur_r);
            end
        end else begin
            if (cur_y < YMIN_A + cur_r) begin
                y_bounce   = 1'b1;
                next_y_dir = 1'b1;
            end else begin
                next_y = YW'(cur_y - cur_r);
            end
        end

        x_bounce   = 1'b0;
        lhs_evt    = 1'b0;
        rhs_evt    = 1'b0;
        next_x     = x_q[idx];
        next_x_dir = x_dir_q[idx];
        if (x_dir_q[idx] && (cur_x + BOX_A + cur_r > XMAX_A)) begin
            if (right_hit) begin
                x_bounce   = 1'b1;
                next_x_dir = 1'b0;
            end else begin
                lhs_evt = 1'b1;
            end
        end else if (!x_dir_q[idx] && (cur_x < XMIN_A + cur_r)) begin
            if (left_hit) begin
                x_bounce   = 1'b1;
                next_x_dir = 1'b1;
            end else begin
                rhs_evt = 1'b1;
            end
        end else if (x_dir_q[idx]) begin
            next_x = XW'(cur_x + cur_r);
        end else begin
            next_x = XW'(cur_x - cur_r);
        end

        next_rate = rate_q[idx];
        if (accel_pass) begin
            next_rate = (rate_q[idx] < MAXR_V) ? rate_q[idx] + RW'(1) : MAXR_V;
        end
    end

    // Scan FSM plus all slot state; enable low freezes everything and silences the pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            idx         <= '0;
            accel_cnt   <= '0;
            accel_pass  <= 1'b0;
            update_done <= 1'b0;
            lhs_score   <= 1'b0;
            rhs_score   <= 1'b0;
            bounce      <= 1'b0;
            event_idx   <= '0;
            x_dir_q     <= '1;
            y_dir_q     <= '1;
            active_q    <= '0;
            for (int i = 0; i < N_BALLS; i++) begin
                x_q[i]     <= CX;
                y_q[i]     <= CY;
                old_x_q[i] <= CX;
                old_y_q[i] <= CY;
                rate_q[i]  <= RATE_V;
            end
        end else if (!enable) begin
            update_done <= 1'b0;
            lhs_score   <= 1'b0;
            rhs_score   <= 1'b0;
            bounce      <= 1'b0;
        end else begin
            update_done <= 1'b0;
            lhs_score   <= 1'b0;
            rhs_score   <= 1'b0;
            bounce      <= 1'b0;
            case (state)
                IDLE: begin
                    if (spawn) begin
                        active_q[spawn_idx] <= 1'b1;
                        x_q[spawn_idx]      <= CX;
                        y_q[spawn_idx]      <= CY;
                        old_x_q[spawn_idx]  <= CX;
                        old_y_q[spawn_idx]  <= CY;
                        rate_q[spawn_idx]   <= RATE_V;
                        x_dir_q[spawn_idx]  <= spawn_dir;
                        y_dir_q[spawn_idx]  <= 1'b1;
                    end
                    if (frame_tick) begin
                        state <= SCAN;
                        idx   <= '0;
                        if (accel_cnt == ACC_LAST) begin
                            accel_cnt  <= '0;
                            accel_pass <= 1'b1;
                        end else begin
                            accel_cnt  <= accel_cnt + CW'(1);
                            accel_pass <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (active_q[idx]) begin
                        old_x_q[idx] <= x_q[idx];
                        old_y_q[idx] <= y_q[idx];
                        if (lhs_evt || rhs_evt) begin
                            active_q[idx] <= 1'b0;
                            x_q[idx]      <= CX;
                            y_q[idx]      <= CY;
                            rate_q[idx]   <= RATE_V;
                            lhs_score     <= lhs_evt;
                            rhs_score     <= rhs_evt;
                            event_idx     <= idx;
                        end else begin
                            x_q[idx]     <= next_x;
                            y_q[idx]     <= next_y;
                            x_dir_q[idx] <= next_x_dir;
                            y_dir_q[idx] <= next_y_dir;
                            rate_q[idx]  <= next_rate;
                            bounce       <= x_bounce || y_bounce;
                            if (x_bounce || y_bounce) begin
                                event_idx <= idx;
                            end
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state       <= DONE;
                        update_done <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_ball_engine.sv
// Randomised self-checking bench for multi_ball_engine against a frame-level ball model.
`timescale 1ns/100ps
module tb_multi_ball_engine;

    localparam int N      = 4;
    localparam int ACCEL  = 3;
    localparam int XMAX   = 640;
    localparam int YMIN   = 20;
    localparam int YMAX   = 480;
    localparam int BOX    = 4;
    localparam int XMIN   = 6;
    localparam int PH     = 15;
    localparam int RATE0  = 1;
    localparam int MAXR   = 15;
    localparam int CX     = 320;
    localparam int CY     = 250;

    logic        clk = 1'b0;
    logic        resetn, enable, frame_tick, spawn, spawn_dir;
    logic [1:0]  spawn_idx, rd_idx;
    logic [9:0]  left_paddle_y, right_paddle_y;
    logic [10:0] rd_x, rd_old_x;
    logic [9:0]  rd_y, rd_old_y;
    logic [4:0]  rd_rate;
    logic [3:0]  active_mask;
    logic        busy, update_done, lhs_score, rhs_score, bounce;
    logic [1:0]  event_idx;

    int vectors = 0;
    int miscompares = 0;

    int mx[N], my[N], mox[N], moy[N], mr[N], mxd[N], myd[N], mact[N];
    int mcnt;
    bit ev_l[N], ev_r[N], ev_b[N];

    multi_ball_engine #(.N_BALLS(N), .ACCEL_FRAMES(ACCEL)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
        .spawn(spawn), .spawn_idx(spawn_idx), .spawn_dir(spawn_dir),
        .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_old_x(rd_old_x), .rd_old_y(rd_old_y),
        .rd_rate(rd_rate), .active_mask(active_mask), .busy(busy), .update_done(update_done),
        .lhs_score(lhs_score), .rhs_score(rhs_score), .bounce(bounce), .event_idx(event_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = CX; my[i] = CY; mox[i] = CX; moy[i] = CY;
            mr[i] = RATE0; mxd[i] = 1; myd[i] = 1; mact[i] = 0;
            ev_l[i] = 0; ev_r[i] = 0; ev_b[i] = 0;
        end
        mcnt = 0;
    endfunction

    function automatic void model_spawn(int i, int d);
        mact[i] = 1; mx[i] = CX; my[i] = CY; mox[i] = CX; moy[i] = CY;
        mr[i] = RATE0; mxd[i] = d; myd[i] = 1;
    endfunction

    function automatic bit overlaps(int y, int p);
        return (y < p + PH) && (y + BOX > p);
    endfunction

    // One full frame of the game, slot by slot, straight from the ball rules.
    function automatic void model_pass(int lp, int rp);
        bit acc, scored, hit;
        int r, nx, ny, nxd, nyd;
        acc = (mcnt == ACCEL - 1);
        mcnt = acc ? 0 : mcnt + 1;
        for (int i = 0; i < N; i++) begin
            ev_l[i] = 0; ev_r[i] = 0; ev_b[i] = 0;
            if (mact[i] == 0) continue;
            r = mr[i]; mox[i] = mx[i]; moy[i] = my[i];
            hit = 0; scored = 0;
            ny = my[i]; nyd = myd[i];
            if (myd[i] == 1 && my[i] + BOX + r > YMAX) begin nyd = 0; hit = 1; end
            else if (myd[i] == 0 && my[i] < YMIN + r) begin nyd = 1; hit = 1; end
            else ny = (myd[i] == 1) ? my[i] + r : my[i] - r;
            nx = mx[i]; nxd = mxd[i];
            if (mxd[i] == 1 && mx[i] > XMAX - BOX - r) begin
                if (overlaps(my[i], rp)) begin nxd = 0; hit = 1; end
                else begin ev_l[i] = 1; scored = 1; end
            end else if (mxd[i] == 0 && mx[i] < XMIN + r) begin
                if (overlaps(my[i], lp)) begin nxd = 1; hit = 1; end
                else begin ev_r[i] = 1; scored = 1; end
            end else begin
                nx = (mxd[i] == 1) ? mx[i] + r : mx[i] - r;
            end
            if (scored) begin
                mact[i] = 0; mx[i] = CX; my[i] = CY; mr[i] = RATE0;
            end else begin
                mx[i] = nx; my[i] = ny; mxd[i] = nxd; myd[i] = nyd;
                mr[i] = acc ? ((r + 1 > MAXR) ? MAXR : r + 1) : r;
                ev_b[i] = hit;
            end
        end
    endfunction

    function automatic logic [3:0] model_mask();
        logic [3:0] m;
        for (int i = 0; i < N; i++) m[i] = (mact[i] != 0);
        return m;
    endfunction

    function automatic int pick_paddle();
        int j, p;
        j = int'($urandom_range(0, N - 1));
        if (mact[j] != 0 && $urandom_range(0, 3) != 0) begin
            p = my[j] - int'($urandom_range(0, 14));
            return (p < 0) ? 0 : p;
        end
        return int'($urandom_range(0, 470));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; enable = 1'b1; frame_tick = 1'b0; spawn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            vectors++;
            if (rd_x !== 11'(mx[i]) || rd_y !== 10'(my[i]) || rd_old_x !== 11'(mox[i]) ||
                rd_old_y !== 10'(moy[i]) || rd_rate !== 5'(mr[i])) begin
                miscompares++;
                $display("[TB] FAIL %s slot%0d: got x=%0d y=%0d ox=%0d oy=%0d r=%0d, expected x=%0d y=%0d ox=%0d oy=%0d r=%0d",
                         tag, i, rd_x, rd_y, rd_old_x, rd_old_y, rd_rate, mx[i], my[i], mox[i], moy[i], mr[i]);
            end
        end
        vectors++;
        if (active_mask !== model_mask()) begin
            miscompares++;
            $display("[TB] FAIL %s active_mask: got %b expected %b", tag, active_mask, model_mask());
        end
    endtask

    task automatic spawn_idle(input int i, input int d);
        spawn = 1'b1; spawn_idx = 2'(i); spawn_dir = 1'(d);
        model_spawn(i, d);
        step();
        spawn = 1'b0;
    endtask

    // Drives one accepted frame and checks busy, done and every event pulse cycle by cycle.
    task automatic run_pass(input int lp, input int rp, input bit sp, input int sidx,
                            input int sdir, input int junk_c);
        logic [2:0] exp_ev;
        int ei;
        left_paddle_y = 10'(lp); right_paddle_y = 10'(rp);
        if (sp) begin
            spawn = 1'b1; spawn_idx = 2'(sidx); spawn_dir = 1'(sdir);
            model_spawn(sidx, sdir);
        end
        frame_tick = 1'b1;
        model_pass(lp, rp);
        step();
        frame_tick = 1'b0; spawn = 1'b0;
        for (int c = 1; c <= N + 2; c++) begin
            ei = c - 2;
            exp_ev = (ei >= 0 && ei < N) ? {ev_l[ei], ev_r[ei], ev_b[ei]} : 3'b000;
            vectors++;
            if (busy !== (c <= N + 1) || update_done !== (c == N + 1)) begin
                miscompares++;
                $display("[TB] FAIL pass_ctrl cycle %0d: got busy=%b done=%b expected busy=%b done=%b",
                         c, busy, update_done, (c <= N + 1), (c == N + 1));
            end
            vectors++;
            if ({lhs_score, rhs_score, bounce} !== exp_ev) begin
                miscompares++;
                $display("[TB] FAIL pass_events cycle %0d: got lhs/rhs/bounce=%b expected %b",
                         c, {lhs_score, rhs_score, bounce}, exp_ev);
            end
            if (exp_ev != 3'b000) begin
                vectors++;
                if (event_idx !== 2'(ei)) begin
                    miscompares++;
                    $display("[TB] FAIL event_idx cycle %0d: got %0d expected %0d", c, event_idx, ei);
                end
            end
            if (c == junk_c) begin
                frame_tick = 1'b1; spawn = 1'b1;
                spawn_idx = 2'($urandom_range(0, N - 1)); spawn_dir = 1'($urandom_range(0, 1));
            end else begin
                frame_tick = 1'b0; spawn = 1'b0;
            end
            if (c < N + 2) step();
        end
        frame_tick = 1'b0; spawn = 1'b0;
        check_slots("pass");
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (busy !== 1'b0 || update_done !== 1'b0 || {lhs_score, rhs_score, bounce} !== 3'b000 ||
            event_idx !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b ev=%b idx=%0d expected all 0",
                     busy, update_done, {lhs_score, rhs_score, bounce}, event_idx);
        end
        check_slots("reset");
    endtask

    task automatic test_first_pass();
        spawn_idle(0, 1);
        run_pass(0, 0, 1'b0, 0, 0, 0);
        rd_idx = 2'd0;
        #1;
        vectors++;
        if (rd_x !== 11'd321 || rd_y !== 10'd251 || rd_old_x !== 11'd320 || rd_old_y !== 10'd250) begin
            miscompares++;
            $display("[TB] FAIL first_pass: got (%0d,%0d) old (%0d,%0d) expected (321,251) old (320,250)",
                     rd_x, rd_y, rd_old_x, rd_old_y);
        end
    endtask

    task automatic test_accel();
        for (int t = 2; t <= 7; t++) begin
            run_pass(0, 0, 1'b0, 0, 0, 0);
            rd_idx = 2'd0;
            #1;
            vectors++;
            if (rd_rate !== 5'(1 + t / 3)) begin
                miscompares++;
                $display("[TB] FAIL accel tick %0d: got rate=%0d expected %0d", t, rd_rate, 1 + t / 3);
            end
        end
    endtask

    task automatic test_busy_drops();
        run_pass(0, 0, 1'b0, 0, 0, 2);
        run_pass(0, 0, 1'b0, 0, 0, N + 1);
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_drop: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_enable_stall();
        int done_c;
        done_c = -1;
        left_paddle_y = 10'd0; right_paddle_y = 10'd0;
        frame_tick = 1'b1;
        model_pass(0, 0);
        step();
        frame_tick = 1'b0;
        for (int c = 1; c <= N + 8; c++) begin
            if (update_done === 1'b1 && done_c < 0) done_c = c;
            enable = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            step();
        end
        enable = 1'b1;
        vectors++;
        if (done_c != N + 6) begin
            miscompares++;
            $display("[TB] FAIL enable_stall: got update_done at cycle %0d expected %0d", done_c, N + 6);
        end
        check_slots("stall");
    endtask

    task automatic test_multi();
        int guard;
        do_reset();
        spawn_idle(1, 1);
        spawn_idle(3, 1);
        for (int k = 0; k < 10; k++) run_pass(0, 0, 1'b0, 0, 0, 0);
        spawn_idle(0, 0);
        spawn_idle(2, 0);
        guard = 0;
        while ((mact[1] != 0 || mact[3] != 0) && guard < 200) begin
            run_pass(0, 0, 1'b0, 0, 0, 0);
            guard++;
        end
        vectors++;
        if (active_mask !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL multi_mask: got %b expected 0101 after %0d passes", active_mask, guard);
        end
        guard = 0;
        while (model_mask() != 4'b0000 && guard < 200) begin
            run_pass(0, 0, 1'b0, 0, 0, 0);
            guard++;
        end
        vectors++;
        if (active_mask !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL multi_clear: got %b expected 0000 after %0d passes", active_mask, guard);
        end
    endtask

    task automatic test_random();
        int lp, rp, junk, sp;
        for (int k = 0; k < 350; k++) begin
            if ($urandom_range(0, 7) == 0)
                spawn_idle(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1)));
            lp = pick_paddle();
            rp = pick_paddle();
            sp = ($urandom_range(0, 3) == 0) ? 1 : 0;
            junk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 1)) : 0;
            run_pass(lp, rp, sp[0], int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1)), junk);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 0;
        spawn_idle(2, 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        model_reset();
        vectors++;
        if (busy !== 1'b0 || active_mask !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got busy=%b mask=%b expected 0 and 0000", busy, active_mask);
        end
        for (int c = 0; c < N + 3; c++) begin
            if (update_done === 1'b1) saw_done = 1;
            step();
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_done: got update_done=1 expected none");
        end
        check_slots("reset_mid");
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b1; frame_tick = 1'b0; spawn = 1'b0; spawn_dir = 1'b0;
        spawn_idx = 2'd0; rd_idx = 2'd0; left_paddle_y = 10'd0; right_paddle_y = 10'd0;
        model_reset();
        test_reset();
        test_first_pass();
        test_accel();
        test_busy_drops();
        test_enable_stall();
        test_multi();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
